// File: rtl/mic_frame_reader.sv
// mic_frame_reader: pulls one frame of FRAME_LEN samples from the microphone
// FIFO per start request, scales each to OUT_WIDTH with saturation, and streams
// them out on valid/ready with first/last markers through a 3-entry buffer.
module mic_frame_reader #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned EXT_W     = ((DATA_WIDTH > OUT_WIDTH) ? DATA_WIDTH : OUT_WIDTH) + 1;
    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned PTR_W     = 2;

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]     req_cnt;
    logic [CNT_W-1:0]     acc_cnt;
    logic                 inflight;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W-1:0]     occ;
    logic [OUT_WIDTH-1:0] buf_mem [BUF_DEPTH];

    logic                 xfer;
    logic [OUT_WIDTH-1:0] conv_data;

    // Arithmetic shift then clamp into the signed OUT_WIDTH range.
    function automatic logic [OUT_WIDTH-1:0] convert(input logic [DATA_WIDTH-1:0] d);
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] s;
        ext = {{(EXT_W - DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
        s   = ext >>> SHIFT;
        if (s > SAT_MAX) begin
            convert = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            convert = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            convert = s[OUT_WIDTH-1:0];
        end
    endfunction

    // Modulo-3 pointer advance for the output buffer.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign conv_data = convert(fifo_data);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, read-credit and stream output decode.
    always_comb begin
        state_nxt = state;
        fifo_r_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = (state == S_RUN) && (occ != 2'd0);
        out_data  = buf_mem[head];
        out_first = out_valid && (acc_cnt == CNT_W'(0));
        out_last  = out_valid && (acc_cnt == CNT_W'(FRAME_LEN - 1));
        xfer      = out_valid && out_ready;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                fifo_r_en = !fifo_empty
                            && (req_cnt < CNT_W'(FRAME_LEN))
                            && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
                if (xfer && out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters, read-latency tracking and the 3-entry output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt  <= '0;
            acc_cnt  <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    inflight <= fifo_r_en;
                    if (fifo_r_en) begin
                        req_cnt <= req_cnt + CNT_W'(1);
                    end
                    if (inflight) begin
                        buf_mem[tail] <= conv_data;
                        tail          <= ptr_inc(tail);
                    end
                    if (xfer) begin
                        head    <= ptr_inc(head);
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                    case ({inflight, xfer})
                        2'b10:   occ <= occ + 2'd1;
                        2'b01:   occ <= occ - 2'd1;
                        default: occ <= occ;
                    endcase
                end
                S_DONE: begin
                    inflight <= 1'b0;
                end
                default: begin
                    req_cnt  <= '0;
                    acc_cnt  <= '0;
                    inflight <= 1'b0;
                    head     <= '0;
                    tail     <= '0;
                    occ      <= '0;
                    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                        buf_mem[i] <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_frame_reader.sv
// Testbench for mic_frame_reader: FIFO model with one-cycle read latency,
// randomized data and backpressure, and a plain-arithmetic scaling model.
module tb_mic_frame_reader;

    localparam int unsigned DW = 24;
    localparam int unsigned OW = 16;
    localparam int unsigned SH = 4;
    localparam int unsigned FL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mic_frame_reader #(
        .DATA_WIDTH(DW),
        .OUT_WIDTH (OW),
        .SHIFT     (SH),
        .FRAME_LEN (FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fifo_empty(fifo_empty),
        .fifo_r_en (fifo_r_en),
        .fifo_data (fifo_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          first;
        logic          last;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fifo_q [$];
    logic [OW-1:0] exp_q  [$];
    obs_t          obs_q  [$];
    int            obs_cyc[$];

    int cyc, rd_cnt, rd_empty_cnt, done_cnt, done_cyc, xfer_cnt, max_out;

    // Reference scaling: floor-divide by 2^SH, then clamp to signed OW bits.
    function automatic logic [OW-1:0] ref_conv(input logic [DW-1:0] raw);
        int v;
        v = int'(raw);
        if (raw[DW-1]) v = v - (1 << DW);
        v = v >>> SH;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return OW'(v);
    endfunction

    task automatic fifo_push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(ref_conv(v));
        fifo_empty = 1'b0;
    endtask

    task automatic clear_stats();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        rd_cnt = 0; rd_empty_cnt = 0; done_cnt = 0; done_cyc = -1;
        xfer_cnt = 0; max_out = 0; cyc = 0;
    endtask

    // One clock: observe just before the edge, then model the FIFO read port.
    task automatic tick();
        logic r;
        logic e;
        obs_t o;
        @(negedge clk);
        r = fifo_r_en;
        e = fifo_empty;
        if (r) rd_cnt++;
        if (r && e) rd_empty_cnt++;
        if (out_valid && out_ready) begin
            o.data = out_data; o.first = out_first; o.last = out_last;
            obs_q.push_back(o);
            obs_cyc.push_back(cyc);
            xfer_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (r && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        if (rd_cnt - xfer_cnt > max_out) max_out = rd_cnt - xfer_cnt;
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done_cnt > d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        fifo_data = '0; fifo_empty = 1'b1;
        #3;
        n_tests++;
        if ({fifo_r_en, out_valid, out_first, out_last, busy, done, out_data} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {fifo_r_en, out_valid, out_first, out_last, busy, done, out_data});
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 000", {busy, done, out_valid});
        end
    endtask

    task automatic test_basic_frame();
        clear_stats();
        for (int k = 1; k <= int'(FL); k++) fifo_push(DW'(k * 16));
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 20 && cyc < 11; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_tests++;
        if (obs_q.size() != int'(FL)) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), FL);
        end
        for (int i = 0; i < obs_q.size() && i < int'(FL); i++) begin
            n_tests++;
            if (obs_q[i] !== {OW'(i + 1), i == 0, i == int'(FL) - 1} || obs_cyc[i] != i + 3) begin
                n_fail++;
                $display("FAIL basic_sample%0d: got %h@%0d expected %h@%0d", i, obs_q[i],
                         obs_cyc[i], {OW'(i + 1), i == 0, i == int'(FL) - 1}, i + 3);
            end
        end
        n_tests++;
        if (done_cnt != 1 || done_cyc != int'(FL) + 3) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses@%0d expected 1@%0d", done_cnt, done_cyc, FL + 3);
        end
        n_tests++;
        if (rd_cnt != int'(FL)) begin
            n_fail++;
            $display("FAIL basic_reads: got %0d expected %0d", rd_cnt, FL);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_ignored: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] sat_exp [4];
        bit ok;
        sat_exp[0] = 16'h7FFF; sat_exp[1] = 16'h8000;
        sat_exp[2] = 16'h0012; sat_exp[3] = 16'hFFFF;
        clear_stats();
        fifo_push(24'h7FFFFF); fifo_push(24'h800000);
        fifo_push(24'h000120); fifo_push(24'hFFFFF0);
        for (int k = 4; k < int'(FL); k++) fifo_push(DW'($urandom));
        out_ready = 1'b1;
        pulse_start();
        wait_done(50, ok);
        tick();
        n_tests++;
        if (!ok || obs_q.size() != int'(FL)) begin
            n_fail++;
            $display("FAIL sat_frame: got done=%0d count=%0d expected 1/%0d", ok, obs_q.size(), FL);
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i].data !== sat_exp[i]) begin
                n_fail++;
                $display("FAIL sat_const%0d: got %h expected %h", i, obs_q[i].data, sat_exp[i]);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {exp_q[i], i == 0, i == int'(FL) - 1}) begin
                n_fail++;
                $display("FAIL sat_model%0d: got %h expected %h", i, obs_q[i],
                         {exp_q[i], i == 0, i == int'(FL) - 1});
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_stats();
        for (int k = 0; k < int'(FL); k++) fifo_push(DW'($urandom));
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 20 && xfer_cnt < 2; i++) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (max_out != 3) begin
            n_fail++;
            $display("FAIL bp_credit: got outstanding %0d expected 3", max_out);
        end
        n_tests++;
        if (fifo_q.size() != int'(FL) - 5) begin
            n_fail++;
            $display("FAIL bp_fifo_retained: got %0d expected %0d", fifo_q.size(), FL - 5);
        end
        out_ready = 1'b1;
        wait_done(50, ok);
        tick();
        n_tests++;
        if (!ok || obs_q.size() != int'(FL) || max_out > 3) begin
            n_fail++;
            $display("FAIL bp_frame: got done=%0d count=%0d max=%0d expected 1/%0d/3",
                     ok, obs_q.size(), max_out, FL);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {exp_q[i], i == 0, i == int'(FL) - 1}) begin
                n_fail++;
                $display("FAIL bp_sample%0d: got %h expected %h", i, obs_q[i],
                         {exp_q[i], i == 0, i == int'(FL) - 1});
            end
        end
    endtask

    task automatic test_starvation();
        bit ok;
        clear_stats();
        for (int k = 0; k < 3; k++) fifo_push(DW'($urandom));
        out_ready = 1'b1;
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_tests++;
        if (rd_cnt != 3 || obs_q.size() != 3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_wait: got reads=%0d xfers=%0d busy=%b expected 3/3/1",
                     rd_cnt, obs_q.size(), busy);
        end
        for (int k = 3; k < int'(FL); k++) fifo_push(DW'($urandom));
        wait_done(50, ok);
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (!ok || done_cnt != 1 || busy !== 1'b0 || rd_empty_cnt != 0) begin
            n_fail++;
            $display("FAIL starve_done: got done=%0d pulses=%0d busy=%b empty_reads=%0d expected 1/1/0/0",
                     ok, done_cnt, busy, rd_empty_cnt);
        end
        n_tests++;
        if (obs_q.size() != int'(FL)) begin
            n_fail++;
            $display("FAIL starve_count: got %0d expected %0d", obs_q.size(), FL);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {exp_q[i], i == 0, i == int'(FL) - 1}) begin
                n_fail++;
                $display("FAIL starve_sample%0d: got %h expected %h", i, obs_q[i],
                         {exp_q[i], i == 0, i == int'(FL) - 1});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        clear_stats();
        for (int k = 0; k < int'(FL); k++) fifo_push(DW'($urandom));
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 30 && xfer_cnt < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({fifo_r_en, out_valid, out_first, out_last, busy, done, out_data} !== 22'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {fifo_r_en, out_valid, out_first, out_last, busy, done, out_data});
        end
        tick();
        rst = 1'b0;
        fifo_q.delete();
        fifo_data = '0;
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got pulses=%0d busy=%b expected 0/0", done_cnt, busy);
        end
        clear_stats();
        for (int k = 0; k < int'(FL); k++) fifo_push(DW'($urandom));
        pulse_start();
        wait_done(50, ok);
        tick();
        n_tests++;
        if (!ok || obs_q.size() != int'(FL) || done_cnt != 1) begin
            n_fail++;
            $display("FAIL midreset_refill: got done=%0d count=%0d pulses=%0d expected 1/%0d/1",
                     ok, obs_q.size(), done_cnt, FL);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {exp_q[i], i == 0, i == int'(FL) - 1}) begin
                n_fail++;
                $display("FAIL midreset_sample%0d: got %h expected %h", i, obs_q[i],
                         {exp_q[i], i == 0, i == int'(FL) - 1});
            end
        end
    endtask

    task automatic test_random_frames();
        int pushed;
        bit ok;
        for (int f = 0; f < 4; f++) begin
            clear_stats();
            pushed = 0;
            ok = 1'b0;
            out_ready = 1'b1;
            pulse_start();
            for (int i = 0; i < 400 && !ok; i++) begin
                out_ready = ($urandom_range(0, 9) < 7);
                if (pushed < int'(FL) && $urandom_range(0, 2) != 0) begin
                    fifo_push(DW'($urandom));
                    pushed++;
                end
                tick();
                if (done_cnt > 0) ok = 1'b1;
            end
            out_ready = 1'b1;
            tick();
            n_tests++;
            if (!ok || obs_q.size() != int'(FL) || rd_empty_cnt != 0 || max_out > 3) begin
                n_fail++;
                $display("FAIL rand%0d_frame: got done=%0d count=%0d empty_reads=%0d max=%0d expected 1/%0d/0/<=3",
                         f, ok, obs_q.size(), rd_empty_cnt, max_out, FL);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_tests++;
                if (obs_q[i] !== {exp_q[i], i == 0, i == int'(FL) - 1}) begin
                    n_fail++;
                    $display("FAIL rand%0d_sample%0d: got %h expected %h", f, i, obs_q[i],
                             {exp_q[i], i == 0, i == int'(FL) - 1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_backpressure();
        test_starvation();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mic_frame_reader.md
# mic_frame_reader

Drains 24-bit microphone samples from the microphone sample FIFO's read port and delivers exactly one frame of `FRAME_LEN` samples per `start` request. Each sample is scaled to `OUT_WIDTH` bits and passed downstream on a valid/ready stream marked with first/last flags. The block sits between the microphone FIFO and the feature-extraction front end of the speech pipeline. It absorbs the FIFO's one-cycle registered read latency and downstream backpressure without losing or duplicating samples.

## Interface
- `DATA_WIDTH`, 24: FIFO sample width, two's complement.
- `OUT_WIDTH`, 16: output sample width, two's complement.
- `SHIFT`, 8: arithmetic right shift applied before saturation; legal range 0..DATA_WIDTH-1.
- `FRAME_LEN`, 256: samples per frame; must be ≥ 2.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to capture one frame; ignored unless in IDLE.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_r_en` out 1: FIFO read enable.
- `fifo_data` in DATA_WIDTH: FIFO `data_out`; valid on the cycle after an accepted read.
- `out_data` out OUT_WIDTH: scaled sample.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the sample.
- `out_first` out 1: current sample is sample 0 of the frame.
- `out_last` out 1: current sample is sample FRAME_LEN-1 of the frame.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse on the cycle after the last sample is accepted.

## Operation
- Reset: state IDLE; `fifo_r_en`, `out_valid`, `out_first`, `out_last`, `busy`, `done` = 0; `out_data` = 0; all counters and buffer pointers = 0.
- State IDLE:
  - `start`=1 moves to RUN.
  - Clears the request counter `req_cnt`, the accept counter `acc_cnt` and the buffer.
- State RUN, FIFO reads:
  - `fifo_r_en` = !fifo_empty && req_cnt < FRAME_LEN && (inflight + occ) < 3.
  - `inflight` is 1 when `fifo_r_en` was asserted in the previous cycle.
  - `occ` is the occupancy of the 3-entry output buffer.
  - This credit rule keeps the buffer from overflowing under any `out_ready` pattern.
- State RUN, capture:
  - When `inflight`=1, `fifo_data` is converted and written to the buffer tail.
  - `req_cnt` increments on every asserted `fifo_r_en`.
- State RUN, output:
  - Head entry drives `out_data`; `out_valid` = (occ != 0).
  - A transfer occurs when `out_valid && out_ready`. It pops the head and increments `acc_cnt`.
  - `out_first` = valid && acc_cnt==0; `out_last` = valid && acc_cnt==FRAME_LEN-1.
  - The transfer with `out_last`=1 moves the state to DONE.
- State DONE: `done`=1 and `busy`=1 for one cycle, then IDLE.
- Conversion: `s` = signed(fifo_data) >>> SHIFT, sign-extended.
  - If s > 2^(OUT_WIDTH-1)-1, output 0x7FF…F.
  - If s < -2^(OUT_WIDTH-1), output 0x80…0.
  - Otherwise output the low OUT_WIDTH bits of `s`.
- Empty FIFO: `fifo_r_en` is never asserted while `fifo_empty`=1. RUN waits indefinitely for samples.
- Simultaneous capture and pop in the same cycle: occupancy is unchanged and order is preserved.
- `start` outside IDLE is ignored, including in the DONE cycle.
- Reset mid-frame: immediate return to reset values. Partially read samples are discarded, and no `done` pulse is produced.

## Timing
- `start` sampled at edge 0, so RUN begins in cycle 1.
- Earliest `fifo_r_en` is in cycle 1; the sample appears on `fifo_data` in cycle 2 and is captured at the end of cycle 2.
- Earliest `out_valid` is cycle 3: latency from `fifo_r_en` to `out_valid` is 2 cycles.
- With a non-empty FIFO and `out_ready`=1, throughput is 1 sample/cycle.
- Frame with continuous flow: first sample in cycle 3, last in cycle FRAME_LEN+2, `done` in cycle FRAME_LEN+3, IDLE in cycle FRAME_LEN+4.
- Outputs are registered or decoded from registered state only; there are no combinational paths from `out_ready` or `fifo_empty` to `out_valid`.
- The `fifo_r_en` path from `fifo_empty` is combinational.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. All outputs go to 0 immediately and `busy`=0.
- Basic frame: FRAME_LEN=4, SHIFT=8. FIFO preloaded with 0x000100, 0x000200, 0x000300, 0x000400; `out_ready`=1; `start` pulse.
  - `out_data` = 1, 2, 3, 4 in cycles 3–6, `out_first` on 1, `out_last` on 4.
  - `done` in cycle 7.
  - Exactly 4 `fifo_r_en` cycles.
- Saturation: SHIFT=4, inputs 0x7FFFFF, 0x800000, 0x000120, 0xFFFFF0 → outputs 0x7FFF, 0x8000, 0x0012, 0xFFFF.
- Backpressure: FRAME_LEN=16, `out_ready`=0 for 10 cycles starting after the 2nd transfer.
  - `fifo_r_en` stops once inflight+occ=3.
  - All 16 values arrive in order with no duplicates.
  - The FIFO retains the unread samples.
- Starvation and start-while-busy: FIFO empty for 20 cycles mid-frame and `start` pulsed in RUN.
  - `fifo_r_en` stays 0 while the FIFO is empty.
  - The frame resumes when data arrives.
  - Only one `done` pulse occurs.
- Reset mid-frame: `rst` pulse after 5 transfers with FRAME_LEN=8. No `done`; a new `start` yields a full 8-sample frame with `out_first` on its first sample.
